// File: rtl/if_prefetch_pkg.sv
// Shared constants for the instruction-fetch prefetch stage.
// Stall-vector bit positions and the canonical NOP encoding.
package if_prefetch_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    localparam int STALL_IF  = 0;
    localparam int STALL_ID  = 1;
    localparam int STALL_EX  = 2;
    localparam int STALL_MEM = 3;
    localparam int STALL_WB  = 4;

endpackage

// File: rtl/if_prefetch_if.sv
// Fetch-stage bus: redirect/stall inputs, IRAM port and if_id head.
// master = the prefetch stage, slave = its environment.
interface if_prefetch_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 30
);

    logic              bj_flag;
    logic [XLEN-1:0]   bj_addr;
    logic [4:0]        pipe_stall;
    logic [31:0]       inst;
    logic              iram_en;
    logic [ADDR_W-1:0] inst_raddr;
    logic [XLEN-1:0]   if_pc;
    logic [31:0]       if_inst;
    logic              if_valid;

    modport master (
        input  bj_flag, bj_addr, pipe_stall, inst,
        output iram_en, inst_raddr, if_pc, if_inst, if_valid
    );

    modport slave (
        output bj_flag, bj_addr, pipe_stall, inst,
        input  iram_en, inst_raddr, if_pc, if_inst, if_valid
    );

endinterface

// File: rtl/if_prefetch_fifo.sv
// Circular sync FIFO holding {pc, inst} pairs for the fetch stage.
// Flush clears occupancy only; storage is left as-is.
module if_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   cnt,
    output logic [WIDTH-1:0]         head
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   cnt <= cnt + (PW+1)'(1);
                2'b01:   cnt <= cnt - (PW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/if_prefetch.sv
// Fetch stage: credit-limited sequential IRAM issue into a prefetch
// FIFO, with same-cycle redirect on taken branch/jump.
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              ADDR_W   = 30,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [31:0]     NOP_INST = INST_NOP
) (
    input logic          clk,
    input logic          rst_n,
    if_prefetch_if.master bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int W  = 2 * XLEN;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [XLEN-1:0] tgt_pc;
    logic            rsp_vld;
    logic            bj;
    logic            issue;
    logic            fire;
    logic            push;
    logic            pop;
    logic            empty;
    logic [PW:0]     cnt;
    logic [PW+1:0]   used;
    logic [W-1:0]    head;
    logic            unused_ok;

    assign unused_ok = ^{bus.pipe_stall[4:1], bus.bj_addr[1:0]};

    assign bj     = bus.bj_flag & rst_n;
    assign tgt_pc = {bus.bj_addr[XLEN-1:2], 2'b00};
    // in-flight response already owns a slot
    assign used   = {1'b0, cnt} + (PW+2)'(rsp_vld);
    assign issue  = rst_n & (used < (PW+2)'(DEPTH));
    assign fire   = bj | issue;
    assign empty  = (cnt == '0);
    assign push   = rsp_vld & ~bj;
    assign pop    = ~empty & ~bus.pipe_stall[STALL_IF];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= '0;
            rsp_vld  <= 1'b0;
        end else begin
            rsp_vld <= fire;
            if (bj) begin
                rsp_pc   <= tgt_pc;
                fetch_pc <= tgt_pc + XLEN'(4);
            end else if (issue) begin
                rsp_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + XLEN'(4);
            end
        end
    end

    if_fifo #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (bj),
        .push  (push),
        .din   ({rsp_pc, XLEN'(bus.inst)}),
        .pop   (pop),
        .cnt   (cnt),
        .head  (head)
    );

    assign bus.iram_en    = fire;
    assign bus.inst_raddr = bj ? tgt_pc[ADDR_W+1:2]
                               : fetch_pc[ADDR_W+1:2];
    assign bus.if_valid   = ~empty;
    assign bus.if_pc      = empty ? '0 : head[W-1:XLEN];
    assign bus.if_inst    = empty ? NOP_INST : head[31:0];

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: scoreboard of {pc, inst} on pops,
// plus cycle-exact checks of issue, redirect, stall and reset.
module tb_if_prefetch;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    ent_t exp_q[$];

    if_prefetch_if b0 ();
    if_prefetch_if b1 ();

    if_prefetch dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0)
    );

    if_prefetch #(
        .RESET_PC (32'hFFFF_FFFC)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] iw(input logic [31:0] pc);
        return 32'h100 + {2'b00, pc[31:2]};
    endfunction

    // IRAM word k holds 0x100 + k, one-cycle read latency
    always @(posedge clk) begin
        if (b0.iram_en) b0.inst <= 32'h100 + {2'b00, b0.inst_raddr};
        if (b1.iram_en) b1.inst <= 32'h100 + {2'b00, b1.inst_raddr};
    end

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_seq(input logic [31:0] pc0, input int n);
        for (int i = 0; i < n; i++) begin
            ent_t e;
            e.pc   = pc0 + 32'(4 * i);
            e.inst = iw(e.pc);
            exp_q.push_back(e);
        end
    endtask

    task automatic cyc(input logic bj,
                       input logic [31:0] a,
                       input logic st);
        @(posedge clk);
        #1;
        b0.bj_flag    = bj;
        b0.bj_addr    = a;
        b0.pipe_stall = {4'b0000, st};
        #3;
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        b0.bj_flag    = 1'b0;
        b0.bj_addr    = '0;
        b0.pipe_stall = '0;
        #3;
    endtask

    // consumed heads must follow the expected stream
    always @(negedge clk) begin
        if (rst_n && b0.if_valid && !b0.pipe_stall[0] && !b0.bj_flag) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 64'(b0.if_pc), 64'hFFFF_FFFF);
            end else begin
                ent_t e;
                e = exp_q.pop_front();
                chk("sb_pc", 64'(b0.if_pc), 64'(e.pc));
                chk("sb_inst", 64'(b0.if_inst), 64'(e.inst));
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            checks++;
            assert (!(dut0.u_fifo.push && dut0.u_fifo.cnt == 3'd4)) else begin
                errors++;
                $error("FAIL overflow observed=push_at_full expected=none");
            end
        end
    end

    initial begin
        errors        = 0;
        checks        = 0;
        rst_n         = 1'b0;
        b0.bj_flag    = 1'b0;
        b0.bj_addr    = '0;
        b0.pipe_stall = '0;
        b1.bj_flag    = 1'b0;
        b1.bj_addr    = '0;
        b1.pipe_stall = '0;

        repeat (2) @(posedge clk);
        #4;
        chk("rst_en", 64'(b0.iram_en), 64'd0);
        chk("rst_valid", 64'(b0.if_valid), 64'd0);
        chk("rst_pc", 64'(b0.if_pc), 64'd0);
        chk("rst_inst", 64'(b0.if_inst), 64'h13);

        // sequential stream, then a long IF stall
        exp_q.delete();
        push_seq(32'h0, 40);
        release_rst();
        chk("c0_en", 64'(b0.iram_en), 64'd1);
        chk("c0_raddr", 64'(b0.inst_raddr), 64'd0);
        chk("c0_valid", 64'(b0.if_valid), 64'd0);
        cyc(1'b0, 32'h0, 1'b0);
        chk("c1_raddr", 64'(b0.inst_raddr), 64'd1);
        chk("c1_valid", 64'(b0.if_valid), 64'd0);
        cyc(1'b0, 32'h0, 1'b0);
        chk("c2_valid", 64'(b0.if_valid), 64'd1);
        chk("c2_pc", 64'(b0.if_pc), 64'd0);
        chk("c2_inst", 64'(b0.if_inst), 64'h100);
        for (int i = 3; i <= 10; i++) begin
            cyc(1'b0, 32'h0, 1'b1);
            chk("stall_pc", 64'(b0.if_pc), 64'h4);
            chk("stall_inst", 64'(b0.if_inst), 64'h101);
            if (i >= 5) chk("stall_en", 64'(b0.iram_en), 64'd0);
        end
        for (int i = 11; i <= 20; i++) cyc(1'b0, 32'h0, 1'b0);

        // redirect from a fresh start
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        push_seq(32'h0, 3);
        release_rst();
        for (int i = 1; i <= 4; i++) cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b1, 32'h14, 1'b0);
        chk("bj_en", 64'(b0.iram_en), 64'd1);
        chk("bj_raddr", 64'(b0.inst_raddr), 64'd5);
        chk("bj_head_pc", 64'(b0.if_pc), 64'hC);
        exp_q.delete();
        push_seq(32'h14, 5);
        cyc(1'b0, 32'h0, 1'b0);
        chk("bj_gap", 64'(b0.if_valid), 64'd0);
        cyc(1'b0, 32'h0, 1'b0);
        chk("bj_tgt_pc", 64'(b0.if_pc), 64'h14);
        chk("bj_tgt_inst", 64'(b0.if_inst), 64'h105);
        cyc(1'b0, 32'h0, 1'b0);
        chk("bj_next_pc", 64'(b0.if_pc), 64'h18);
        cyc(1'b0, 32'h0, 1'b0);

        // redirect under stall drops the in-flight response
        cyc(1'b1, 32'h40, 1'b1);
        exp_q.delete();
        push_seq(32'h40, 3);
        cyc(1'b0, 32'h0, 1'b1);
        chk("bjs_empty", 64'(b0.if_valid), 64'd0);
        cyc(1'b0, 32'h0, 1'b1);
        chk("bjs_pc", 64'(b0.if_pc), 64'h40);
        chk("bjs_inst", 64'(b0.if_inst), 64'h110);
        cyc(1'b0, 32'h0, 1'b1);
        chk("bjs_hold", 64'(b0.if_pc), 64'h40);
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);

        // back-to-back redirects: the later target wins
        cyc(1'b1, 32'h80, 1'b0);
        exp_q.delete();
        push_seq(32'h80, 2);
        cyc(1'b1, 32'h100, 1'b0);
        chk("b2b_raddr", 64'(b0.inst_raddr), 64'h40);
        exp_q.delete();
        push_seq(32'h100, 4);
        cyc(1'b0, 32'h0, 1'b0);
        chk("b2b_gap", 64'(b0.if_valid), 64'd0);
        cyc(1'b0, 32'h0, 1'b0);
        chk("b2b_pc", 64'(b0.if_pc), 64'h100);
        chk("b2b_inst", 64'(b0.if_inst), 64'h140);
        cyc(1'b0, 32'h0, 1'b0);

        // fill the queue, then reset asynchronously mid-cycle
        for (int i = 0; i < 8; i++) cyc(1'b0, 32'h0, 1'b1);
        chk("full_cnt", 64'(dut0.u_fifo.cnt), 64'd4);
        chk("full_en", 64'(b0.iram_en), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("arst_en", 64'(b0.iram_en), 64'd0);
        chk("arst_valid", 64'(b0.if_valid), 64'd0);
        chk("arst_pc", 64'(b0.if_pc), 64'd0);
        chk("arst_cnt", 64'(dut0.u_fifo.cnt), 64'd0);
        chk("arst_en1", 64'(b1.iram_en), 64'd0);
        exp_q.delete();
        push_seq(32'h0, 4);
        release_rst();
        chk("rs_raddr", 64'(b0.inst_raddr), 64'd0);
        chk("wrap_raddr", 64'(b1.inst_raddr), 64'h3FFF_FFFF);
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);
        chk("rs_pc", 64'(b0.if_pc), 64'd0);
        chk("wrap_pc0", 64'(b1.if_pc), 64'hFFFF_FFFC);
        chk("wrap_inst0", 64'(b1.if_inst), 64'(iw(32'hFFFF_FFFC)));
        cyc(1'b0, 32'h0, 1'b0);
        chk("wrap_pc1", 64'(b1.if_pc), 64'h0);
        chk("wrap_inst1", 64'(b1.if_inst), 64'h100);
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);

        @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
